// File: rtl/md5_wb_pkg.sv
// md5_wb_pkg: slave word indices, sequencer states and poll-counter sizing
package md5_wb_pkg;
  localparam logic [4:0] IDX_CTRL = 5'd0;
  localparam logic [4:0] IDX_DATA0 = 5'd1;
  localparam logic [4:0] IDX_VALID = 5'd17;
  localparam logic [4:0] IDX_HASH0 = 5'd18;
  localparam logic [4:0] IDX_MRST = 5'd22;
  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_WR_DATA, S_WR_START, S_WR_STOP,
    S_WAIT_HASH, S_RD_HASH, S_DONE, S_RST1, S_RST0
  } state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/wb_xfer_ctrl.sv
// wb_xfer_ctrl: one Wishbone classic transfer per request, idle gap after each, or back-to-back while i_hold
module wb_xfer_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          i_hold,
  input  logic          i_we,
  input  logic [AW-1:0] i_adr,
  input  logic [DW-1:0] i_dat,
  output logic          o_done,
  output logic          o_err,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);
  logic          r_cyc;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dat;
  assign o_done   = r_cyc & (wb_ack_i | wb_err_i);
  assign o_err    = r_cyc & wb_err_i;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;
  assign wb_we_o  = r_we;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  // address/data are latched at launch so they stay frozen across wait states
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc <= 1'b0;
      r_we  <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
    end else if (!r_cyc) begin
      r_cyc <= i_req;
      if (i_req) begin
        r_we  <= i_we;
        r_adr <= i_adr;
        r_dat <= i_dat;
      end
    end else if (o_done) begin
      r_cyc <= wb_ack_i & ~wb_err_i & i_hold;
    end
  end
endmodule

// File: rtl/md5_wb_master.sv
// md5_wb_master: loads a padded block into the MD5 slave over Wishbone, starts it,
// polls for completion and returns the digest; aborts via message_reset on error or timeout
module md5_wb_master import md5_wb_pkg::*; #(
  parameter int            AW           = 32,
  parameter int            DW           = 32,
  parameter logic [AW-1:0] BASE_ADDR    = '0,
  parameter int            POLL_TIMEOUT = 4096
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          blk_valid_i,
  output logic          blk_ready_o,
  input  logic [511:0]  blk_data_i,
  output logic          hash_valid_o,
  output logic [127:0]  hash_o,
  output logic          busy_o,
  output logic          err_o
);
  localparam int CW = cnt_w(POLL_TIMEOUT);
  state_t        r_state, w_next;
  logic [511:0]  r_blk;
  logic [127:0]  r_hash;
  logic [3:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_req, w_hold, w_we, w_done, w_xerr, w_poll, w_tmo, w_last;
  logic [4:0]    w_idx;
  logic [DW-1:0] w_dat;
  assign w_poll = r_state inside {S_WAIT_RDY, S_WAIT_HASH};
  assign w_tmo  = r_cnt == CW'(POLL_TIMEOUT - 1);
  assign w_last = r_idx == (r_state == S_RD_HASH ? 4'd3 : 4'd15);
  wb_xfer_ctrl #(.AW(AW), .DW(DW)) u_xfer (
    .clk(wb_clk_i), .rst(wb_rst_i), .i_req(w_req), .i_hold(w_hold), .i_we(w_we),
    .i_adr(BASE_ADDR + AW'({w_idx, 2'b00})), .i_dat(w_dat), .o_done(w_done), .o_err(w_xerr),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );
  always_comb begin
    w_next = r_state;
    w_req  = !(r_state inside {S_IDLE, S_DONE});
    w_we   = !(w_poll || r_state == S_RD_HASH);
    w_hold = w_poll & ~wb_dat_i[0] & ~w_tmo;
    w_idx  = IDX_CTRL;
    w_dat  = '0;
    case (r_state)
      S_IDLE:      if (blk_valid_i) w_next = S_WAIT_RDY;
      S_WAIT_RDY:  if (w_done) w_next = wb_dat_i[0] ? S_WR_DATA : w_tmo ? S_RST1 : S_WAIT_RDY;
      S_WR_DATA: begin
        w_idx = IDX_DATA0 + 5'(r_idx);
        w_dat = r_blk[32*r_idx +: 32];
        if (w_done && w_last) w_next = S_WR_START;
      end
      S_WR_START: begin
        w_dat = 32'd1;
        if (w_done) w_next = S_WR_STOP;
      end
      S_WR_STOP:   if (w_done) w_next = S_WAIT_HASH;
      S_WAIT_HASH: begin
        w_idx = IDX_VALID;
        if (w_done) w_next = wb_dat_i[0] ? S_RD_HASH : w_tmo ? S_RST1 : S_WAIT_HASH;
      end
      S_RD_HASH: begin
        w_idx = IDX_HASH0 + 5'(r_idx);
        if (w_done && w_last) w_next = S_DONE;
      end
      S_DONE:      w_next = S_IDLE;
      S_RST1: begin
        w_idx = IDX_MRST;
        w_dat = 32'd1;
        if (w_done) w_next = S_RST0;
      end
      S_RST0: begin
        w_idx = IDX_MRST;
        if (w_done) w_next = S_IDLE;
      end
      default:     w_next = S_IDLE;
    endcase
    if (w_xerr && !(r_state inside {S_RST1, S_RST0})) w_next = S_RST1;
  end
  // word index and poll count restart on every state change
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_blk   <= '0;
      r_hash  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= r_state == S_RST0 && w_done;
      r_idx   <= w_next != r_state ? '0 : r_idx + 4'(w_done);
      r_cnt   <= w_next != r_state ? '0 : r_cnt + CW'(w_done && w_poll);
      if (r_state == S_IDLE && blk_valid_i) r_blk <= blk_data_i;
      if (r_state == S_RD_HASH && w_done && !w_xerr) r_hash[32*r_idx[1:0] +: 32] <= wb_dat_i;
    end
  end
  assign wb_sel_o     = 4'hF;
  assign blk_ready_o  = r_state == S_IDLE && !wb_rst_i;
  assign busy_o       = r_state != S_IDLE && !wb_rst_i;
  assign hash_valid_o = r_state == S_DONE && !wb_rst_i;
  assign hash_o       = r_hash;
  assign err_o        = r_err;
endmodule

// File: tb/tb_md5_wb_master.sv
// tb_md5_wb_master: behavioural MD5 slave BFM with write/result scoreboards for md5_wb_master
module tb_md5_wb_master;
  logic         clk = 1'b0, rst = 1'b1;
  logic [31:0]  adr, dat_o, dat_i = '0;
  logic [3:0]   sel;
  logic         we, cyc, stb, ack = 1'b0, berr = 1'b0;
  logic         blk_valid = 1'b0, blk_ready, hval, herr, busy;
  logic [511:0] blk_data = '0;
  logic [127:0] hash;
  int errors = 0, checks = 0;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic e; logic [127:0] h;} res_t;
  wr_t  exp_wr[$];
  res_t exp_res[$];
  int waits = 0, ready_en = 1, hv_mode = 0, err_on = 0;
  logic [31:0] dig[4] = '{32'hECF8427E, 32'hE9800998, 32'h8F00B204, 32'hD41D8CD9};
  int rdy_polls = 0, dw_cnt = 0, hs_polls = 0, sc = 1000, wcnt = 0;
  logic in_xfer = 1'b0, h_we;
  logic [31:0] h_adr, h_dat;
  localparam logic [127:0] D0 = 128'hD41D8CD98F00B204E9800998ECF8427E;
  localparam logic [127:0] D1 = 128'h0123456789ABCDEFFEDCBA9876543210;

  md5_wb_master #(.POLL_TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i),
    .wb_sel_o(sel), .wb_we_o(we), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_ack_i(ack),
    .wb_err_i(berr), .blk_valid_i(blk_valid), .blk_ready_o(blk_ready), .blk_data_i(blk_data),
    .hash_valid_o(hval), .hash_o(hash), .busy_o(busy), .err_o(herr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [511:0] mk(input int seed);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = {8'(seed), 8'(i), 16'(seed * 97 + i * 13)};
    return b;
  endfunction

  // slave BFM + write monitor: decides ack/err at negedge, sampled by the DUT at the next posedge
  always @(negedge clk) begin
    wr_t e;
    ack = 1'b0;
    berr = 1'b0;
    sc++;
    if (rst) begin
      wcnt = 0;
      in_xfer = 1'b0;
    end else begin
      if (blk_valid && blk_ready) begin
        rdy_polls = 0;
        dw_cnt = 0;
        hs_polls = 0;
      end
      if (cyc && stb) begin
        if (in_xfer) chk("hold_stable", {adr, dat_o, 31'd0, we}, {h_adr, h_dat, 31'd0, h_we});
        else begin
          h_adr = adr;
          h_dat = dat_o;
          h_we = we;
          in_xfer = 1'b1;
        end
        if (wcnt < waits) wcnt++;
        else begin
          wcnt = 0;
          in_xfer = 1'b0;
          if (we) begin
            if (adr >= 32'h04 && adr <= 32'h40) dw_cnt++;
            if (adr >= 32'h04 && adr <= 32'h40 && dw_cnt == err_on) berr = 1'b1;
            else begin
              ack = 1'b1;
              if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got adr %h dat %h, required none", adr, dat_o);
              end else begin
                e = exp_wr.pop_front();
                chk("wr_adr", adr, e.a);
                chk("wr_dat", dat_o, e.d);
              end
              if (adr == 32'h0 && dat_o == 32'h1) sc = 0;
            end
          end else begin
            ack = 1'b1;
            dat_i = '0;
            if (adr == 32'h00) begin
              rdy_polls++;
              dat_i = 32'(ready_en);
            end else if (adr == 32'h44) begin
              hs_polls++;
              dat_i = hv_mode == 0 ? 32'(hs_polls >= 3) : hv_mode == 1 ? 32'(sc == 7) : 32'd0;
            end else if (adr >= 32'h48 && adr <= 32'h54) dat_i = dig[(adr - 32'h48) >> 2];
          end
        end
      end else begin
        wcnt = 0;
        in_xfer = 1'b0;
      end
    end
  end

  // result monitor
  always @(negedge clk) begin
    res_t r;
    if (!rst && (hval || herr)) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got hash_valid=%0b err=%0b, required none", hval, herr);
      end else begin
        r = exp_res.pop_front();
        chk("pulse_kind", {hval, herr}, r.e ? 2'b01 : 2'b10);
        chk("hash", hash, r.h);
      end
    end
  end

  // kind: 0 success, 1 timeout abort, 2 bus error on data write err_on, 3 no result expected
  task automatic send(input logic [511:0] b, input int kind, input logic [127:0] eh);
    wr_t w;
    res_t r;
    logic acc = 1'b0;
    int n = kind == 2 ? err_on - 1 : kind == 1 ? 0 : 16;
    for (int i = 0; i < n; i++) begin
      w.a = 32'(4 * (i + 1));
      w.d = b[32*i +: 32];
      exp_wr.push_back(w);
    end
    w.a = (kind == 0 || kind == 3) ? 32'h00 : 32'h58;
    w.d = 32'd1;
    exp_wr.push_back(w);
    w.d = 32'd0;
    exp_wr.push_back(w);
    if (kind < 3) begin
      r.e = kind != 0;
      r.h = eh;
      exp_res.push_back(r);
    end
    blk_data = b;
    blk_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = blk_ready;
      step();
    end
    blk_valid = 1'b0;
    chk("accept", acc, 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_res.size() != 0 || exp_wr.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 3000, 1);
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_sel", sel, 4'hF);
    chk("rst_ready", blk_ready, 0);
    chk("rst_flags", {hval, herr, busy}, 0);
    chk("rst_hash", hash, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", blk_ready, 1);
    step();
    send(mk(1), 0, D0);
    wait_done("zero_wait_done");
    chk("hs_polls", hs_polls, 3);
    waits = 2;
    send(mk(2), 0, D0);
    wait_done("wait_state_done");
    waits = 0;
    hv_mode = 1;
    dig = '{32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567};
    send(mk(3), 0, D1);
    wait_done("pulse_done");
    ready_en = 0;
    send(mk(4), 1, D1);
    wait_done("timeout_done");
    chk("timeout_polls", rdy_polls, 16);
    ready_en = 1;
    err_on = 5;
    send(mk(5), 2, D1);
    wait_done("buserr_done");
    err_on = 0;
    @(negedge clk);
    chk("after_err_ready", blk_ready, 1);
    chk("after_err_busy", busy, 0);
    step();
    hv_mode = 2;
    send(mk(6), 3, 0);
    begin
      int n = 0;
      while (!(cyc && adr == 32'h44) && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("reach_wait_hash", n < 500, 1);
    end
    step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cyc_stb", {cyc, stb}, 0);
    chk("midrst_pulses", {hval, herr}, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", blk_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_hash", hash, 0);
    chk("midrst_writes_left", exp_wr.size(), 0);
    repeat (20) @(negedge clk);
    chk("results_left", exp_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
